gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the number of GPIO pins (1..32).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, meaning reset; synchronous, active-low.
REQ-004 The block SHALL have port ce, input, 1 bit, meaning chip enable from the bus controller's GPIO select.
REQ-005 The block SHALL have port re, input, 1 bit, meaning bus read strobe.
REQ-006 The block SHALL have port we, input, 4 bits, meaning per-byte write enables (bit k covers wdata[8k+7:8k]).
REQ-007 The block SHALL have port addr, input, 8 bits, meaning byte address; only addr[4:2] is decoded and addr[7:5], addr[1:0] are ignored.
REQ-008 The block SHALL have port wdata, input, 32 bits, meaning bus write data.
REQ-009 The block SHALL have port rdata, output, 32 bits, meaning bus read data.
REQ-010 The block SHALL have port gpio_i, input, WIDTH bits, meaning asynchronous pin inputs.
REQ-011 The block SHALL have port gpio_o, output, WIDTH bits, meaning pin output values.
REQ-012 The block SHALL have port gpio_oe, output, WIDTH bits, meaning pin output enables (1 = drive).
REQ-013 The block SHALL have port irq, output, 1 bit, meaning level interrupt request.

Function
REQ-014 The register map SHALL be: 0x00 OUT (RW), 0x04 DIR (RW), 0x08 IN (RO, debounced state), 0x0C IRQ_EN (RW), 0x10 IRQ_PEND (W1C), 0x14 EDGE (RW, 1 = rising, 0 = falling), 0x18 DEBOUNCE (RW, 16 bits), 0x1C reserved.
REQ-015 A write SHALL occur on the rising clk edge when ce=1 and we!=0, updating only the enabled bytes; bits at or above WIDTH (DEBOUNCE: at or above 16) SHALL be ignored on write and read as 0.
REQ-016 Writes to IN and to 0x1C SHALL have no effect; reads of 0x1C SHALL return 0.
REQ-017 rdata SHALL be combinational with zero-cycle latency: the selected register when ce=1 and re=1, otherwise 0x00000000.
REQ-018 gpio_o SHALL equal OUT and gpio_oe SHALL equal DIR, both registered with no extra delay.
REQ-019 gpio_i SHALL pass through a two-flop synchronizer (sync2) before any other use.
REQ-020 When DEBOUNCE=0, the debounced state (deb) SHALL load sync2 on every clock, so an input change settled before edge 1 is visible in IN after edge 3.
REQ-021 When DEBOUNCE=D>0, a 16-bit prescaler SHALL count 0..D and then wrap to 0, asserting tick when its count equals D.
REQ-022 On each tick, the block SHALL capture sync2 into samp, and each deb bit SHALL take sync2 only where sync2 equals the previous samp (two consecutive agreeing ticks).
REQ-023 Any write to DEBOUNCE SHALL clear the prescaler to 0 on the same edge.
REQ-024 An edge event SHALL be defined per bit as deb changing 0->1 with EDGE=1, or 1->0 with EDGE=0, and SHALL set that IRQ_PEND bit on the same edge that deb updates.
REQ-025 IRQ_PEND bits SHALL set regardless of IRQ_EN.
REQ-026 Writing 1 to an IRQ_PEND bit SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-027 If an edge event and a W1C occur on the same bit in the same cycle, set SHALL win.
REQ-028 irq SHALL equal the OR over all bits of (IRQ_PEND & IRQ_EN), combinational from registers.
REQ-029 The first deb update after reset (flag primed=0) SHALL load deb without generating edge events and then set primed=1.

Reset
REQ-030 On a rising clk edge with rst_n=0, the block SHALL clear OUT, DIR, IRQ_EN, IRQ_PEND, EDGE, DEBOUNCE, the prescaler, sync flops, samp, deb and primed.
REQ-031 After reset, gpio_o=0, gpio_oe=0 and irq=0, and rdata SHALL follow REQ-017.
REQ-032 Reset asserted mid-debounce or with pending interrupts SHALL discard all in-progress state with no residual event after release.

Verification
REQ-033 Bench: write 0x0000A5A5 with we=0011 to 0x00, then 0xFFFFFFFF with we=0001 to 0x04 -> gpio_o=0xA5A5, gpio_oe=0x00FF, reading 0x04 returns 0x000000FF.
REQ-034 Bench: reset released with gpio_i=0xFFFF, DEBOUNCE=0 -> IN reads 0xFFFF after 3 clocks and IRQ_PEND stays 0.
REQ-035 Bench: DEBOUNCE=0, EDGE[0]=1, IRQ_EN[0]=1, gpio_i[0] 0->1 -> IRQ_PEND=0x0001 and irq=1 after edge 3; writing 0x1 to 0x10 -> irq=0 next cycle.
REQ-036 Bench: DEBOUNCE=4 and gpio_i[1] glitches high for 3 cycles -> IN[1] stays 0; gpio_i[1] held high -> IN[1]=1 within 5 to 10 cycles after sync.
REQ-037 Bench: W1C of bit 2 issued in the same cycle as a bit-2 edge event -> IRQ_PEND[2] remains 1.
REQ-038 Bench: rst_n low for 1 cycle while irq=1 and gpio_o=0xFFFF -> irq=0, gpio_o=0 and all registers read 0.

Source files
------------

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: output/direction registers, debounced and synchronized inputs,
// and per-pin edge interrupts with write-one-to-clear pending bits.
module gpio_port #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             re,
   input  logic [3:0]       we,
   input  logic [7:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   logic [WIDTH-1:0] out_q, dir_q, irq_en_q, irq_pend_q, edge_sel_q;
   logic [WIDTH-1:0] sync1_q, sync2_q, samp_q, deb_q;
   logic [WIDTH-1:0] deb_d, agree, edge_ev, w1c, pend_d, bm_w;
   logic [15:0]      dbc_q, presc_q, presc_d;
   logic             primed_q, tick, deb_upd, wr_en;
   logic             wr_out, wr_dir, wr_ien, wr_pend, wr_edge, wr_dbc;
   logic [2:0]       sel;
   logic [31:0]      bmask, rd;
   logic             unused_bits;

   assign sel     = addr[4:2];
   assign bmask   = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
   assign bm_w    = bmask[WIDTH-1:0];
   assign wr_en   = ce && (we != 4'b0000);
   assign wr_out  = wr_en && (sel == 3'd0);
   assign wr_dir  = wr_en && (sel == 3'd1);
   assign wr_ien  = wr_en && (sel == 3'd3);
   assign wr_pend = wr_en && (sel == 3'd4);
   assign wr_edge = wr_en && (sel == 3'd5);
   assign wr_dbc  = wr_en && (sel == 3'd6);

   assign unused_bits = ^{addr[7:5], addr[1:0], wdata, bmask};

   always_comb begin
      tick    = (dbc_q != 16'd0) && (presc_q == dbc_q);
      deb_upd = (dbc_q == 16'd0) || tick;
      // A bit only moves when two consecutive tick samples agree
      agree   = ~(sync2_q ^ samp_q);
      if (dbc_q == 16'd0) begin
         deb_d = sync2_q;
      end else begin
         deb_d = (sync2_q & agree) | (deb_q & ~agree);
      end
      // Event: bit changed and its new level matches the selected edge sense
      edge_ev = '0;
      if (deb_upd && primed_q) begin
         edge_ev = (deb_d ^ deb_q) & ~(deb_d ^ edge_sel_q);
      end
      w1c    = wr_pend ? (wdata[WIDTH-1:0] & bm_w) : '0;
      pend_d = (irq_pend_q & ~w1c) | edge_ev;
      if (wr_dbc || deb_upd) begin
         presc_d = 16'd0;
      end else begin
         presc_d = presc_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q      <= '0;
         dir_q      <= '0;
         irq_en_q   <= '0;
         irq_pend_q <= '0;
         edge_sel_q <= '0;
         dbc_q      <= '0;
         presc_q    <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         samp_q     <= '0;
         deb_q      <= '0;
         primed_q   <= 1'b0;
      end else begin
         sync1_q    <= gpio_i;
         sync2_q    <= sync1_q;
         irq_pend_q <= pend_d;
         presc_q    <= presc_d;
         if (wr_out)  out_q      <= (out_q & ~bm_w) | (wdata[WIDTH-1:0] & bm_w);
         if (wr_dir)  dir_q      <= (dir_q & ~bm_w) | (wdata[WIDTH-1:0] & bm_w);
         if (wr_ien)  irq_en_q   <= (irq_en_q & ~bm_w) | (wdata[WIDTH-1:0] & bm_w);
         if (wr_edge) edge_sel_q <= (edge_sel_q & ~bm_w) | (wdata[WIDTH-1:0] & bm_w);
         if (wr_dbc)  dbc_q      <= (dbc_q & ~bmask[15:0]) | (wdata[15:0] & bmask[15:0]);
         if (tick)    samp_q     <= sync2_q;
         if (deb_upd) begin
            deb_q    <= deb_d;
            primed_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rd = 32'd0;
      unique case (sel)
         3'd0:    rd[WIDTH-1:0] = out_q;
         3'd1:    rd[WIDTH-1:0] = dir_q;
         3'd2:    rd[WIDTH-1:0] = deb_q;
         3'd3:    rd[WIDTH-1:0] = irq_en_q;
         3'd4:    rd[WIDTH-1:0] = irq_pend_q;
         3'd5:    rd[WIDTH-1:0] = edge_sel_q;
         3'd6:    rd[15:0]      = dbc_q;
         default: rd = 32'd0;
      endcase
      rdata = (ce && re) ? rd : 32'd0;
   end

   assign gpio_o  = out_q;
   assign gpio_oe = dir_q;
   assign irq     = |(irq_pend_q & irq_en_q);

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: directed scenarios plus randomized bus/pin traffic
// compared against a behavioural register-map model.
module tb_gpio_port;

   localparam int unsigned W  = 16;
   localparam logic [31:0] WM = 32'h0000_FFFF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b0;
   logic          re = 1'b0;
   logic [3:0]    we = 4'b0;
   logic [7:0]    addr = 8'h0;
   logic [31:0]   wdata = 32'h0;
   logic [W-1:0]  gpio_i = '0;
   logic [31:0]   rdata;
   logic [W-1:0]  gpio_o, gpio_oe;
   logic          irq;

   int checks = 0;
   int failures = 0;

   // Model state, kept as plain 32-bit words masked to the pin count
   logic [31:0] m_out, m_dir, m_ien, m_pend, m_edge, m_db, m_presc;
   logic [31:0] m_s1, m_s2, m_samp, m_deb;
   logic        m_primed;

   gpio_port #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .re      (re),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .gpio_i  (gpio_i),
      .gpio_o  (gpio_o),
      .gpio_oe (gpio_oe),
      .irq     (irq)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] a);
      case (a[4:2])
         3'd0:    return m_out;
         3'd1:    return m_dir;
         3'd2:    return m_deb;
         3'd3:    return m_ien;
         3'd4:    return m_pend;
         3'd5:    return m_edge;
         3'd6:    return m_db;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic [31:0] bm, nd, ev, w1c;
      logic        upd, wr;
      logic [2:0]  a;
      if (!rst_n) begin
         m_out = 0; m_dir = 0; m_ien = 0; m_pend = 0; m_edge = 0; m_db = 0; m_presc = 0;
         m_s1 = 0; m_s2 = 0; m_samp = 0; m_deb = 0; m_primed = 1'b0;
      end else begin
         bm = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
         wr = ce && (we != 4'b0);
         a  = addr[4:2];
         if (m_db == 0) begin
            upd = 1'b1;
            nd  = m_s2;
         end else begin
            upd = (m_presc == m_db);
            nd  = m_deb;
            if (upd)
               for (int i = 0; i < W; i++)
                  if (m_s2[i] == m_samp[i]) nd[i] = m_s2[i];
         end
         ev = 0;
         if (upd && m_primed)
            for (int i = 0; i < W; i++)
               if (nd[i] != m_deb[i] && nd[i] == m_edge[i]) ev[i] = 1'b1;
         w1c    = (wr && a == 3'd4) ? (wdata & bm & WM) : 32'h0;
         m_pend = (m_pend & ~w1c) | ev;
         if (wr && a == 3'd6) m_presc = 0;
         else if (m_db == 0 || m_presc == m_db) m_presc = 0;
         else m_presc = m_presc + 1;
         if (upd && m_db != 0) m_samp = m_s2;
         if (upd) begin
            m_deb    = nd;
            m_primed = 1'b1;
         end
         m_s2 = m_s1;
         m_s1 = {16'h0, gpio_i};
         if (wr) begin
            case (a)
               3'd0: m_out  = ((m_out  & ~bm) | (wdata & bm)) & WM;
               3'd1: m_dir  = ((m_dir  & ~bm) | (wdata & bm)) & WM;
               3'd3: m_ien  = ((m_ien  & ~bm) | (wdata & bm)) & WM;
               3'd5: m_edge = ((m_edge & ~bm) | (wdata & bm)) & WM;
               3'd6: m_db   = ((m_db   & ~bm) | (wdata & bm)) & 32'h0000_FFFF;
               default: ;
            endcase
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
      ce = 1'b1; re = 1'b0; we = b; addr = a; wdata = d;
      step();
      we = 4'b0; ce = 1'b0;
   endtask

   task automatic rd_exp(input string tag, input logic [7:0] a, input logic [31:0] exp);
      ce = 1'b1; re = 1'b1; we = 4'b0; addr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic rd_model(input string tag, input logic [7:0] a);
      ce = 1'b1; re = 1'b1; we = 4'b0; addr = a;
      #1;
      chk(tag, rdata, model_read(a));
   endtask

   initial begin
      int n;
      logic [31:0] exp_rd;

      // Reset with all pins high, then release
      rst_n = 1'b0; gpio_i = 16'hFFFF;
      step(); step();
      chk("rst_gpio_o", 32'(gpio_o), 32'h0);
      chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      ce = 1'b1; re = 1'b0; addr = 8'h00; #1;
      chk("rdata_no_re", rdata, 32'h0);
      for (int a = 0; a < 8; a++) rd_exp("rst_reg", 8'(a * 4), 32'h0);

      rst_n = 1'b1; ce = 1'b0; re = 1'b0;
      step(); step();
      rd_exp("in_after_2", 8'h08, 32'h0);
      step();
      rd_exp("in_after_3", 8'h08, 32'h0000_FFFF);
      rd_exp("pend_after_release", 8'h10, 32'h0);

      // Byte-enabled writes
      wr(8'h00, 32'h0000_A5A5, 4'b0011);
      wr(8'h04, 32'hFFFF_FFFF, 4'b0001);
      chk("gpio_o_a5a5", 32'(gpio_o), 32'h0000_A5A5);
      chk("gpio_oe_00ff", 32'(gpio_oe), 32'h0000_00FF);
      rd_exp("dir_read", 8'h04, 32'h0000_00FF);
      rd_exp("out_read_alias", 8'hE0, 32'h0000_A5A5);
      wr(8'h1C, 32'hFFFF_FFFF, 4'b1111);
      rd_exp("reserved_read", 8'h1C, 32'h0);

      // All pins fall with EDGE=0: falling events on every bit
      gpio_i = 16'h0000;
      repeat (4) step();
      rd_exp("pend_falling_all", 8'h10, 32'h0000_FFFF);
      wr(8'h10, 32'h0000_FFFF, 4'b0011);
      rd_exp("pend_w1c_all", 8'h10, 32'h0);

      // Rising edge on bit 0 with interrupt enabled
      wr(8'h14, 32'h1, 4'b0001);
      wr(8'h0C, 32'h1, 4'b0001);
      gpio_i = 16'h0001;
      step(); step();
      chk("irq_before_edge3", 32'(irq), 32'h0);
      step();
      chk("irq_after_edge3", 32'(irq), 32'h1);
      rd_exp("pend_bit0", 8'h10, 32'h0000_0001);
      wr(8'h10, 32'h1, 4'b0001);
      chk("irq_after_w1c", 32'(irq), 32'h0);

      // Debounce = 4: a 3-cycle glitch must be rejected
      wr(8'h18, 32'h4, 4'b0011);
      rd_exp("dbc_read", 8'h18, 32'h4);
      gpio_i = 16'h0003;
      repeat (3) step();
      gpio_i = 16'h0001;
      for (int i = 0; i < 20; i++) begin
         step();
         rd_exp("glitch_rejected", 8'h08, 32'h0000_0001);
      end
      gpio_i = 16'h0003;
      step(); step();
      n = 0;
      rd_exp("in_before_settle", 8'h08, 32'h0000_0001);
      while (n < 20) begin
         step();
         n++;
         rd_model("in_settle_model", 8'h08);
         if (rdata[1]) break;
      end
      chk("deb_latency_5_to_10", 32'((n >= 5) && (n <= 10)), 32'h1);

      // W1C on bit 2 coinciding with its edge event: set wins
      wr(8'h18, 32'h0, 4'b0011);
      wr(8'h14, 32'h5, 4'b0001);
      rd_exp("pend_before_race", 8'h10, 32'h0);
      gpio_i = 16'h0007;
      step(); step();
      wr(8'h10, 32'h4, 4'b0001);
      rd_exp("pend_set_wins", 8'h10, 32'h0000_0004);

      // Reset while irq asserted and outputs driven
      wr(8'h0C, 32'h5, 4'b0001);
      wr(8'h00, 32'h0000_FFFF, 4'b0011);
      chk("irq_before_reset", 32'(irq), 32'h1);
      chk("gpio_o_before_reset", 32'(gpio_o), 32'h0000_FFFF);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("irq_after_reset", 32'(irq), 32'h0);
      chk("gpio_o_after_reset", 32'(gpio_o), 32'h0);
      for (int a = 0; a < 8; a++) rd_exp("reg_after_reset", 8'(a * 4), 32'h0);
      ce = 1'b0; re = 1'b0;
      repeat (6) step();
      rd_exp("no_residual_pend", 8'h10, 32'h0);
      chk("no_residual_irq", 32'(irq), 32'h0);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ (16'($urandom) & 16'($urandom));
         ce    = ($urandom_range(0, 7) != 0);
         re    = 1'($urandom);
         we    = ($urandom_range(0, 9) < 4) ? 4'($urandom) : 4'b0;
         addr  = 8'($urandom);
         wdata = $urandom;
         if (addr[4:2] == 3'd6) wdata[15:0] = 16'($urandom_range(0, 5));
         #1;
         exp_rd = (ce && re) ? model_read(addr) : 32'h0;
         chk("rand_rdata", rdata, exp_rd);
         chk("rand_gpio_o", 32'(gpio_o), m_out);
         chk("rand_gpio_oe", 32'(gpio_oe), m_dir);
         chk("rand_irq", 32'(irq), 32'(|(m_pend & m_ien)));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
